// File: rtl/grid_row_packer_if.sv
// Byte-stream input and bank write port of the grid row packer.
// master: the packer's view (consumes bytes, drives bank writes).
// slave:  the environment's view (byte source plus bank controller).
interface grid_row_packer_if #(
   parameter int TX_DATA_WIDTH   = 32,
   parameter int BANK_ADDR_WIDTH = 8,
   parameter int COL_ADDR_WIDTH  = 8
);
   logic                       byte_valid;
   logic [7:0]                 byte_data;
   logic                       byte_last;
   logic                       byte_ready;
   logic                       busy;
   logic                       write_en;
   logic [BANK_ADDR_WIDTH-1:0] owner_row_addr;
   logic [COL_ADDR_WIDTH-1:0]  col_addr;
   logic [TX_DATA_WIDTH-1:0]   partial_vec_in;

   modport master (
      input  byte_valid, byte_data, byte_last, busy,
      output byte_ready, write_en, owner_row_addr, col_addr, partial_vec_in
   );

   modport slave (
      output byte_valid, byte_data, byte_last, busy,
      input  byte_ready, write_en, owner_row_addr, col_addr, partial_vec_in
   );
endinterface

// File: rtl/grid_row_packer.sv
// Packs a streamed ASCII grid ('@' = 1, '.' = 0) into TX_DATA_WIDTH-bit
// chunks and writes each chunk into the bank at (row, first column of chunk).
// Tracks the grid dimensions and flags malformed input.
module grid_row_packer #(
   parameter int TX_DATA_WIDTH   = 32,
   parameter int BANK_ADDR_WIDTH = 8,
   parameter int COL_ADDR_WIDTH  = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   grid_row_packer_if.master          bus,
   output logic [COL_ADDR_WIDTH-1:0]  grid_width,
   output logic [BANK_ADDR_WIDTH-1:0] grid_rows,
   output logic                       done,
   output logic                       format_err
);
   localparam int IDX_W = $clog2(TX_DATA_WIDTH);
   localparam int BIT_W = IDX_W + 1;

   localparam logic [7:0] CH_ROLL  = 8'h40;   // '@'
   localparam logic [7:0] CH_EMPTY = 8'h2E;   // '.'
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_CR    = 8'h0D;

   typedef enum logic [1:0] {S_ACCUM, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t                     r_state,      w_state_next;
   logic [TX_DATA_WIDTH-1:0]   r_chunk,      w_chunk_next;
   logic [BIT_W-1:0]           r_bit_cnt,    w_bit_cnt_next;
   logic [COL_ADDR_WIDTH-1:0]  r_col_cnt,    w_col_cnt_next;
   // One extra bit so a row starting past the last bank row is detectable.
   logic [BANK_ADDR_WIDTH:0]   r_row,        w_row_next;
   logic                       r_row_end,    w_row_end_next;
   logic                       r_last,       w_last_next;
   logic [COL_ADDR_WIDTH-1:0]  r_grid_width, w_grid_width_next;
   logic [BANK_ADDR_WIDTH-1:0] r_grid_rows,  w_grid_rows_next;
   logic                       r_done,       w_done_next;
   logic                       r_format_err, w_format_err_next;

   logic                       w_accept;
   logic                       w_is_data;
   logic                       w_is_lf;
   logic                       w_is_cr;
   logic                       w_row_ovf;
   logic                       w_finish;
   logic                       w_finish_last;
   logic [COL_ADDR_WIDTH-1:0]  w_finish_col;
   logic [BIT_W-1:0]           w_bit_tmp;
   logic [COL_ADDR_WIDTH-1:0]  w_col_tmp;

   assign w_row_ovf = r_row[BANK_ADDR_WIDTH];
   assign w_is_data = (bus.byte_data == CH_ROLL) || (bus.byte_data == CH_EMPTY);
   assign w_is_lf   = (bus.byte_data == CH_LF);
   assign w_is_cr   = (bus.byte_data == CH_CR);
   assign w_accept  = bus.byte_valid && bus.byte_ready;

   // Output drive: write strobe only in ISSUE with the bank idle; the chunk
   // base column is the column count minus the bits gathered so far.
   assign bus.byte_ready     = (r_state == S_ACCUM);
   assign bus.write_en       = (r_state == S_ISSUE) && !bus.busy && !w_row_ovf;
   assign bus.owner_row_addr = r_row[BANK_ADDR_WIDTH-1:0];
   assign bus.col_addr       = r_col_cnt - COL_ADDR_WIDTH'(r_bit_cnt);
   assign bus.partial_vec_in = r_chunk;
   assign grid_width         = r_grid_width;
   assign grid_rows          = r_grid_rows;
   assign done               = r_done;
   assign format_err         = r_format_err;

   // Next-state logic: byte parsing, write sequencing and row completion.
   always_comb begin
      w_state_next      = r_state;
      w_chunk_next      = r_chunk;
      w_bit_cnt_next    = r_bit_cnt;
      w_col_cnt_next    = r_col_cnt;
      w_row_next        = r_row;
      w_row_end_next    = r_row_end;
      w_last_next       = r_last;
      w_grid_width_next = r_grid_width;
      w_grid_rows_next  = r_grid_rows;
      w_done_next       = r_done;
      w_format_err_next = r_format_err;
      w_finish          = 1'b0;
      w_finish_last     = 1'b0;
      w_finish_col      = r_col_cnt;
      w_bit_tmp         = r_bit_cnt;
      w_col_tmp         = r_col_cnt;

      case (r_state)
         S_ACCUM: begin
            if (w_accept) begin
               if (w_is_data) begin
                  w_chunk_next[r_bit_cnt[IDX_W-1:0]] = (bus.byte_data == CH_ROLL);
                  w_bit_tmp = r_bit_cnt + 1'b1;
                  w_col_tmp = r_col_cnt + 1'b1;
                  if (w_row_ovf) begin
                     w_format_err_next = 1'b1;
                  end
               end else if (!w_is_lf && !w_is_cr) begin
                  w_format_err_next = 1'b1;
               end
               w_bit_cnt_next = w_bit_tmp;
               w_col_cnt_next = w_col_tmp;
               if (w_is_lf || bus.byte_last) begin
                  if (w_bit_tmp != '0) begin
                     w_state_next   = S_ISSUE;
                     w_row_end_next = 1'b1;
                     w_last_next    = bus.byte_last;
                  end else begin
                     w_finish      = 1'b1;
                     w_finish_col  = w_col_tmp;
                     w_finish_last = bus.byte_last;
                  end
               end else if (w_bit_tmp == BIT_W'(TX_DATA_WIDTH)) begin
                  w_state_next   = S_ISSUE;
                  w_row_end_next = 1'b0;
                  w_last_next    = 1'b0;
               end
            end
         end
         S_ISSUE: begin
            if (!bus.busy) begin
               w_state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!bus.busy) begin
               w_chunk_next   = '0;
               w_bit_cnt_next = '0;
               if (r_row_end) begin
                  w_finish       = 1'b1;
                  w_finish_col   = r_col_cnt;
                  w_finish_last  = r_last;
                  w_row_end_next = 1'b0;
                  w_last_next    = 1'b0;
               end else begin
                  w_state_next = S_ACCUM;
               end
            end
         end
         S_DONE: begin
            w_state_next = S_DONE;
         end
         default: begin
            w_state_next = S_ACCUM;
         end
      endcase

      // Row completion; an empty line leaves the row counters untouched.
      if (w_finish) begin
         if (w_finish_col != '0) begin
            if (r_row == '0) begin
               w_grid_width_next = w_finish_col;
            end else if (w_finish_col != r_grid_width) begin
               w_format_err_next = 1'b1;
            end
            if (!w_row_ovf) begin
               w_row_next = r_row + 1'b1;
               if (r_grid_rows != '1) begin
                  w_grid_rows_next = r_grid_rows + 1'b1;
               end
            end
         end
         w_col_cnt_next = '0;
         if (w_finish_last) begin
            w_state_next = S_DONE;
            w_done_next  = 1'b1;
         end else begin
            w_state_next = S_ACCUM;
         end
      end
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= S_ACCUM;
         r_chunk      <= '0;
         r_bit_cnt    <= '0;
         r_col_cnt    <= '0;
         r_row        <= '0;
         r_row_end    <= 1'b0;
         r_last       <= 1'b0;
         r_grid_width <= '0;
         r_grid_rows  <= '0;
         r_done       <= 1'b0;
         r_format_err <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_chunk      <= w_chunk_next;
         r_bit_cnt    <= w_bit_cnt_next;
         r_col_cnt    <= w_col_cnt_next;
         r_row        <= w_row_next;
         r_row_end    <= w_row_end_next;
         r_last       <= w_last_next;
         r_grid_width <= w_grid_width_next;
         r_grid_rows  <= w_grid_rows_next;
         r_done       <= w_done_next;
         r_format_err <= w_format_err_next;
      end
   end
endmodule

// File: tb/tb_grid_row_packer.sv
// Testbench for grid_row_packer: directed table, hand-written corner
// sequences and randomized grids checked against a line-based model.
module tb_grid_row_packer;
   localparam int TX = 32;
   localparam int BA = 8;
   localparam int CA = 8;
   localparam int OBS_MAX = 4096;

   localparam byte CH_AT = 8'h40;
   localparam byte CH_DOT = 8'h2E;
   localparam byte CH_LF = 8'h0A;
   localparam byte CH_CR = 8'h0D;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic [CA-1:0] grid_width;
   logic [BA-1:0] grid_rows;
   logic          done;
   logic          format_err;

   grid_row_packer_if #(.TX_DATA_WIDTH(TX), .BANK_ADDR_WIDTH(BA), .COL_ADDR_WIDTH(CA)) bus ();

   grid_row_packer #(.TX_DATA_WIDTH(TX), .BANK_ADDR_WIDTH(BA), .COL_ADDR_WIDTH(CA)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .grid_width (grid_width),
      .grid_rows  (grid_rows),
      .done       (done),
      .format_err (format_err)
   );

   always #5 clock = ~clock;

   typedef struct {
      int            row;
      int            col;
      logic [TX-1:0] vec;
   } wr_t;

   typedef struct {
      string         txt;
      int            width;
      int            rows;
      bit            err;
      int            nw;
      int            wrow [3];
      int            wcol [3];
      logic [TX-1:0] wvec [3];
   } vec_t;

   wr_t  obs_arr [OBS_MAX];
   int   obs_n = 0;
   int   proto_bad = 0;
   wr_t  exp_q [$];
   byte  cur_q [$];
   int   n_vec = 0;
   int   n_err = 0;
   int   busy_mode = 0;
   bit   busy_force = 1'b0;
   int   gap_max = 0;

   // Write monitor: records every strobe and flags protocol violations.
   initial begin
      bit prev_we;
      prev_we = 1'b0;
      forever begin
         @(negedge clock);
         if (bus.write_en === 1'b1) begin
            if (bus.busy !== 1'b0 || prev_we) proto_bad++;
            if (obs_n < OBS_MAX) begin
               obs_arr[obs_n] = '{int'(bus.owner_row_addr), int'(bus.col_addr), bus.partial_vec_in};
               obs_n++;
            end
         end
         prev_we = (bus.write_en === 1'b1);
      end
   end

   // Busy driver: random or forced, applied 2 time units after the edge.
   initial begin
      bus.busy = 1'b0;
      forever begin
         @(posedge clock);
         #2;
         if (busy_mode != 0) bus.busy = ($urandom_range(0, 99) < 30);
         else bus.busy = busy_force;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic do_reset();
      bus.byte_valid = 1'b0;
      bus.byte_last  = 1'b0;
      bus.byte_data  = 8'h00;
      #2 reset = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input byte b, input bit last);
      bit acc;
      int bound;
      if (gap_max > 0) begin
         repeat ($urandom_range(0, gap_max)) begin
            @(posedge clock);
            #1;
         end
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      bus.byte_last  = last;
      bound = 0;
      forever begin
         @(negedge clock);
         acc = (bus.byte_ready === 1'b1);
         @(posedge clock);
         #1;
         if (acc) break;
         bound++;
         if (bound > 2000) begin
            chk("byte_accept_timeout", 64'd1, 64'd0);
            break;
         end
      end
      bus.byte_valid = 1'b0;
      bus.byte_last  = 1'b0;
   endtask

   task automatic run_grid();
      int cnt;
      for (int i = 0; i < cur_q.size(); i++) send_byte(cur_q[i], i == cur_q.size() - 1);
      cnt = 0;
      while (done !== 1'b1 && cnt < 3000) begin
         @(posedge clock);
         #1;
         cnt++;
      end
      chk("done", 64'(done), 64'd1);
   endtask

   task automatic str_to_q(input string s);
      cur_q.delete();
      for (int i = 0; i < s.len(); i++) cur_q.push_back(byte'(s[i]));
   endtask

   task automatic compare_writes(input int base);
      chk("write_count", 64'(obs_n - base), 64'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && base + k < obs_n; k++) begin
         chk("wr_row", 64'(obs_arr[base+k].row), 64'(exp_q[k].row));
         chk("wr_col", 64'(obs_arr[base+k].col), 64'(exp_q[k].col));
         chk("wr_vec", 64'(obs_arr[base+k].vec), 64'(exp_q[k].vec));
      end
      chk("strobe_protocol", 64'(proto_bad), 64'd0);
   endtask

   // Reference: split the byte stream into lines, chop each non-empty line
   // into TX-wide chunks and compare line lengths against the first line.
   task automatic model(output int w, output int rows, output bit err);
      bit            line [$];
      logic [TX-1:0] v;
      byte           b;
      exp_q.delete();
      w = 0;
      rows = 0;
      err = 1'b0;
      for (int i = 0; i < cur_q.size(); i++) begin
         b = cur_q[i];
         if (b == CH_AT || b == CH_DOT) line.push_back(b == CH_AT);
         else if (b != CH_LF && b != CH_CR) err = 1'b1;
         if (b == CH_LF || i == cur_q.size() - 1) begin
            if (line.size() > 0) begin
               for (int c = 0; c < line.size(); c += TX) begin
                  v = '0;
                  for (int k = 0; k < TX; k++) if (c + k < line.size()) v[k] = line[c+k];
                  exp_q.push_back('{rows, c, v});
               end
               if (rows == 0) w = line.size();
               else if (line.size() != w) err = 1'b1;
               rows++;
            end
            line.delete();
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_write_en"}, 64'(bus.write_en), 64'd0);
      chk({tag, "_row_addr"}, 64'(bus.owner_row_addr), 64'd0);
      chk({tag, "_col_addr"}, 64'(bus.col_addr), 64'd0);
      chk({tag, "_vec"}, 64'(bus.partial_vec_in), 64'd0);
      chk({tag, "_grid_width"}, 64'(grid_width), 64'd0);
      chk({tag, "_grid_rows"}, 64'(grid_rows), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_format_err"}, 64'(format_err), 64'd0);
   endtask

   initial begin
      vec_t  tv [7];
      string s40;
      string s32;
      int    base;
      int    pulses;
      int    mw;
      int    mr;
      bit    me;

      bus.byte_valid = 1'b0;
      bus.byte_last  = 1'b0;
      bus.byte_data  = 8'h00;
      #12;
      check_all_zero("reset");
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
      chk("reset_byte_ready", 64'(bus.byte_ready), 64'd1);

      // Directed table
      s40 = "";
      for (int i = 0; i < 40; i++) s40 = {s40, "@"};
      s32 = "";
      for (int i = 0; i < 16; i++) s32 = {s32, "@."};
      tv[0] = '{"@.@\n.@.\n", 3, 2, 1'b0, 2, '{0, 1, 0}, '{0, 0, 0}, '{32'h5, 32'h2, 32'h0}};
      tv[1] = '{"", 40, 1, 1'b0, 2, '{0, 0, 0}, '{0, 32, 0}, '{32'hFFFF_FFFF, 32'hFF, 32'h0}};
      tv[2] = '{"", 32, 1, 1'b0, 1, '{0, 0, 0}, '{0, 0, 0}, '{32'h5555_5555, 32'h0, 32'h0}};
      tv[3] = '{"@@@\n@@@@\n", 3, 2, 1'b1, 2, '{0, 1, 0}, '{0, 0, 0}, '{32'h7, 32'hF, 32'h0}};
      tv[4] = '{"@x.\n", 2, 1, 1'b1, 1, '{0, 0, 0}, '{0, 0, 0}, '{32'h1, 32'h0, 32'h0}};
      tv[5] = '{"@.\r\n.@\r\n\n", 2, 2, 1'b0, 2, '{0, 1, 0}, '{0, 0, 0}, '{32'h1, 32'h2, 32'h0}};
      tv[6] = '{"@@\n.@", 2, 2, 1'b0, 2, '{0, 1, 0}, '{0, 0, 0}, '{32'h3, 32'h2, 32'h0}};
      tv[1].txt = {s40, "\n"};
      tv[2].txt = {s32, "\n"};

      busy_mode = 1;
      gap_max = 2;
      for (int t = 0; t < 7; t++) begin
         do_reset();
         base = obs_n;
         str_to_q(tv[t].txt);
         run_grid();
         exp_q.delete();
         for (int k = 0; k < tv[t].nw; k++) exp_q.push_back('{tv[t].wrow[k], tv[t].wcol[k], tv[t].wvec[k]});
         compare_writes(base);
         chk("tbl_grid_width", 64'(grid_width), 64'(tv[t].width));
         chk("tbl_grid_rows", 64'(grid_rows), 64'(tv[t].rows));
         chk("tbl_format_err", 64'(format_err), 64'(tv[t].err));
         $display("table vector %0d: writes=%0d width=%0d rows=%0d err=%0b", t, obs_n - base, grid_width, grid_rows, format_err);
      end

      // Busy held high on ISSUE: no strobe, no ready; one pulse after release
      busy_mode = 0;
      gap_max = 0;
      busy_force = 1'b1;
      do_reset();
      base = obs_n;
      send_byte(CH_AT, 1'b0);
      send_byte(CH_LF, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         chk("busy_hold_write_en", 64'(bus.write_en), 64'd0);
         chk("busy_hold_ready", 64'(bus.byte_ready), 64'd0);
      end
      @(posedge clock);
      #1 busy_force = 1'b0;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         if (bus.write_en === 1'b1) pulses++;
      end
      chk("busy_release_pulses", 64'(pulses), 64'd1);
      exp_q.delete();
      exp_q.push_back('{0, 0, 32'h1});
      compare_writes(base);
      chk("busy_done", 64'(done), 64'd1);
      $display("busy hold sequence: pulses=%0d", pulses);

      // Full-chunk latency and no empty second write
      do_reset();
      base = obs_n;
      for (int i = 0; i < 32; i++) send_byte(CH_AT, 1'b0);
      @(negedge clock);
      chk("latency_write_en", 64'(bus.write_en), 64'd1);
      chk("latency_vec", 64'(bus.partial_vec_in), 64'hFFFF_FFFF);
      @(posedge clock);
      #1;
      send_byte(CH_LF, 1'b1);
      repeat (3) @(posedge clock);
      #1;
      exp_q.delete();
      exp_q.push_back('{0, 0, 32'hFFFF_FFFF});
      compare_writes(base);
      chk("latency_width", 64'(grid_width), 64'd32);
      $display("latency sequence: writes=%0d width=%0d", obs_n - base, grid_width);

      // Reset while in WAIT, then restart at row 0
      do_reset();
      send_byte(CH_AT, 1'b0);
      send_byte(CH_LF, 1'b0);
      send_byte(CH_AT, 1'b0);
      send_byte(CH_AT, 1'b0);
      send_byte(CH_LF, 1'b0);
      @(negedge clock);
      chk("wait_pre_write_en", 64'(bus.write_en), 64'd1);
      busy_force = 1'b1;
      @(posedge clock);
      #1;
      @(posedge clock);
      #1 reset = 1'b0;
      #1;
      check_all_zero("wait_reset");
      repeat (2) @(posedge clock);
      #1 busy_force = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1;
      base = obs_n;
      str_to_q(".@\n");
      run_grid();
      exp_q.delete();
      exp_q.push_back('{0, 0, 32'h2});
      compare_writes(base);
      chk("wait_restart_rows", 64'(grid_rows), 64'd1);
      chk("wait_restart_width", 64'(grid_width), 64'd2);
      $display("reset-in-wait sequence: writes=%0d rows=%0d", obs_n - base, grid_rows);

      // Randomized grids against the model
      busy_mode = 1;
      gap_max = 1;
      for (int g = 0; g < 40; g++) begin
         int nrows;
         int width;
         int wr;
         nrows = $urandom_range(1, 4);
         width = $urandom_range(1, 70);
         cur_q.delete();
         for (int r = 0; r < nrows; r++) begin
            wr = width;
            if ($urandom_range(0, 9) == 0) wr = (width > 1 && $urandom_range(0, 1) == 1) ? width - 1 : width + 1;
            for (int c = 0; c < wr; c++) begin
               cur_q.push_back($urandom_range(0, 1) == 1 ? CH_AT : CH_DOT);
               if ($urandom_range(0, 59) == 0) cur_q.push_back(8'h7A);
            end
            if ($urandom_range(0, 3) == 0) cur_q.push_back(CH_CR);
            cur_q.push_back(CH_LF);
         end
         if ($urandom_range(0, 3) == 0) cur_q.push_back(CH_LF);
         else if ($urandom_range(0, 3) == 0) void'(cur_q.pop_back());
         do_reset();
         base = obs_n;
         run_grid();
         model(mw, mr, me);
         compare_writes(base);
         chk("rnd_grid_width", 64'(grid_width), 64'(mw));
         chk("rnd_grid_rows", 64'(grid_rows), 64'(mr));
         chk("rnd_format_err", 64'(format_err), 64'(me));
         $display("random grid %0d: bytes=%0d writes=%0d width=%0d rows=%0d err=%0b", g, cur_q.size(), obs_n - base, grid_width, grid_rows, format_err);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
